xcvr_tx_fifo_wr_arbiter: RTL and testbench
==========================================

Name: xcvr_tx_fifo_wr_arbiter

Overview:
- Shares the 128-bit write port of the transceiver TX FIFO (wrreq/data in, wrfull back) between NUM_SRC pattern sources (e.g. PRBS generator, fixed-pattern generator, host-loaded buffer).
- Round-robin arbitration with burst locking, so a source's burst lands contiguously in the FIFO.
- Honours wrfull without losing words.
- Runs entirely in the FIFO write-clock domain and keeps per-source accepted-word and stall statistics.

Parameters:
- NUM_SRC, 3, number of requesting sources (2..8).
- DATA_W, 128, word width; matches FIFO write width.
- MAX_BURST, 16, maximum beats per grant before forced re-arbitration (2..256).
- CNT_W, 32, width of statistics counters.

Ports:
- clk  in  1  write-side clock, same clock as FIFO wrclk.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  arbitration enable; new grants only while high.
- cnt_clear  in  1  synchronous clear of all statistics counters.
- src_valid  in  NUM_SRC  per-source word valid.
- src_last  in  NUM_SRC  per-source end-of-burst marker, qualified by valid.
- src_data  in  NUM_SRC*DATA_W  packed source words; source i at [i*DATA_W +: DATA_W].
- src_ready  out  NUM_SRC  per-source accept; a beat transfers when valid & ready.
- fifo_data  out  DATA_W  to FIFO data.
- fifo_wrreq  out  1  to FIFO wrreq.
- fifo_wrfull  in  1  from FIFO wrfull.
- busy  out  1  high while in BURST.
- grant_id  out  3  index of granted source; valid while busy.
- word_count  out  NUM_SRC*CNT_W  accepted words per source, packed as src_data.
- stall_count  out  CNT_W  cycles with granted valid blocked by wrfull, saturating.

Behaviour:
- Reset (already decided): one clock; reset is synchronous and active-high.
- On reset:
  - state=IDLE, busy=0, grant_id=0, src_ready=0, fifo_wrreq=0.
  - beat counter=0, all counters=0.
  - last_grant=NUM_SRC-1, so source 0 has first priority.
- Reset mid-burst abandons the burst. No further writes occur, and the source sees ready drop in the same cycle reset is sampled.
- States: IDLE, BURST.
- IDLE:
  - If enable=1 and any src_valid=1, select the first valid source searching from last_grant+1 upward with wrap-around.
  - Register grant_id and last_grant, clear the beat counter, and go to BURST next cycle.
  - Grant latency from valid to first possible write is 1 cycle.
  - No beats transfer in IDLE.
- BURST (g = grant_id):
  - src_ready[g] = ~fifo_wrfull. All other ready bits = 0.
  - fifo_wrreq = src_valid[g] & ~fifo_wrfull, combinational, so wrfull blocks the write in the same cycle and no word is lost.
  - fifo_data = src_data[g] at all times in BURST; it is don't-care when wrreq=0 and is driven 0 in IDLE.
  - Accepted beat = fifo_wrreq=1. Each accepted beat increments the beat counter.
  - Go to IDLE after an accepted beat with src_last[g]=1, or after an accepted beat when the beat counter = MAX_BURST-1 (forced release).
  - src_valid[g] dropping mid-burst does not release the grant; the burst stays locked until last or MAX_BURST.
  - enable dropping mid-burst does not abort; the burst completes, then the block stays in IDLE.
- Back-to-back bursts: one IDLE cycle between bursts, which is the arbitration bubble.
- Single requester: it is re-granted after the bubble.
- Statistics:
  - word_count[g] increments by 1 on each accepted beat and wraps at 2^CNT_W.
  - stall_count increments in BURST when src_valid[g]=1 and fifo_wrfull=1, and saturates at all-ones.
  - cnt_clear zeroes all counters next cycle. cnt_clear in the same cycle as an increment gives 0 (clear wins).
  - Counters are unaffected by enable.
- grant_id is held at its last value in IDLE; busy must be checked before using it.

Test Plan:
- Single source, 4-beat burst (last on beat 4), wrfull=0, sources 0..2 idle except src 0 → first wrreq 1 cycle after valid; 4 consecutive wrreq with data D0..D3; busy falls after beat 4; word_count[0]=4.
- All three sources continuously valid, last every 2 beats → grant order 0,1,2,0,1,2; each grant is 2 wrreq cycles followed by 1 bubble; after 6 grants each word_count=4.
- Source 1 valid with last never asserted, MAX_BURST=16 → exactly 16 beats, forced release, then source 2 (if valid) is granted; word_count[1]=16.
- wrfull asserted for 5 cycles mid-burst with valid held → fifo_wrreq=0 and src_ready=0 during those cycles; no word dropped or duplicated (sequence matches); stall_count=5.
- enable dropped during beat 2 of a 4-beat burst → remaining beats complete, then IDLE with busy=0 while valids stay high; re-enabling resumes round-robin from last_grant+1.
- reset asserted mid-burst at beat 3 → next cycle wrreq=0, ready=0, counters=0; first grant after release goes to source 0. Separately, cnt_clear coinciding with an accepted beat → word_count=0.

Source files
------------

// File: rtl/xcvr_tx_fifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter sharing the TX FIFO write port between pattern sources.
// Latency: grant registered one cycle after valid in IDLE; FIFO write is combinational in BURST.
// Backpressure: wrfull drops src_ready and fifo_wrreq in the same cycle, so no word is lost.
module xcvr_tx_fifo_wr_arbiter #(
    parameter int NUM_SRC   = 3,
    parameter int DATA_W    = 128,
    parameter int MAX_BURST = 16,
    parameter int CNT_W     = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        cnt_clear,
    input  logic [NUM_SRC-1:0]          src_valid,
    input  logic [NUM_SRC-1:0]          src_last,
    input  logic [NUM_SRC*DATA_W-1:0]   src_data,
    output logic [NUM_SRC-1:0]          src_ready,
    output logic [DATA_W-1:0]           fifo_data,
    output logic                        fifo_wrreq,
    input  logic                        fifo_wrfull,
    output logic                        busy,
    output logic [2:0]                  grant_id,
    output logic [NUM_SRC*CNT_W-1:0]    word_count,
    output logic [CNT_W-1:0]            stall_count
);

    localparam int                BEAT_W    = $clog2(MAX_BURST);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(MAX_BURST - 1);
    localparam logic [0:0]        ST_IDLE   = 1'b0;
    localparam logic [0:0]        ST_BURST  = 1'b1;

    logic [0:0]        state;
    logic [2:0]        last_grant;
    logic [BEAT_W-1:0] beat_cnt;
    logic              in_burst;
    logic              accept;
    logic              g_valid;
    logic              g_last;
    logic [DATA_W-1:0] g_data;
    logic              any_req;
    logic [2:0]        pick;

    assign in_burst = (state == ST_BURST);
    // Reset gates the write path combinationally so an abandoned burst writes nothing more.
    assign accept     = in_burst & g_valid & ~fifo_wrfull & ~reset;
    assign fifo_wrreq = accept;
    assign busy       = in_burst;
    assign fifo_data  = in_burst ? g_data : '0;

    // Select the granted source's valid/last/data.
    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_id == 3'(i)) begin
                g_valid = src_valid[i];
                g_last  = src_last[i];
                g_data  = src_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Ready goes only to the granted source and follows wrfull directly.
    always_comb begin
        src_ready = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src_ready[i] = in_burst & ~reset & ~fifo_wrfull & (grant_id == 3'(i));
        end
    end

    // Round-robin search: first valid source starting at last_grant+1, wrapping.
    always_comb begin
        int idx;
        idx     = 0;
        any_req = 1'b0;
        pick    = 3'd0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            idx = int'(last_grant) + k;
            if (idx >= NUM_SRC) idx = idx - NUM_SRC;
            for (int j = 0; j < NUM_SRC; j++) begin
                if (!any_req && (j == idx) && src_valid[j]) begin
                    any_req = 1'b1;
                    pick    = 3'(j);
                end
            end
        end
    end

    // Arbitration FSM: grant in IDLE, hold the grant until last beat or burst limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            grant_id   <= 3'd0;
            last_grant <= 3'(NUM_SRC - 1);
            beat_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable && any_req) begin
                        grant_id   <= pick;
                        last_grant <= pick;
                        beat_cnt   <= '0;
                        state      <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (accept) begin
                        if (g_last || (beat_cnt == BEAT_LAST)) begin
                            state <= ST_IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + BEAT_W'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Per-source accepted-word counters, wrapping; clear wins over increment.
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_wc
        logic [CNT_W-1:0] cnt;
        always_ff @(posedge clk) begin
            if (reset || cnt_clear) begin
                cnt <= '0;
            end else if (accept && (grant_id == 3'(i))) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
        assign word_count[i*CNT_W +: CNT_W] = cnt;
    end

    // Stall counter: granted source has data but the FIFO is full; saturates.
    always_ff @(posedge clk) begin
        if (reset || cnt_clear) begin
            stall_count <= '0;
        end else if (in_burst && g_valid && fifo_wrfull && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_xcvr_tx_fifo_wr_arbiter.sv
// Directed, table-driven bench for the TX FIFO write arbiter.
// Each vector is applied after a rising edge and checked on the falling edge.
// Counter values are checked by hand between phases.
module tb_xcvr_tx_fifo_wr_arbiter;

    localparam int NS = 3;
    localparam int DW = 128;
    localparam int CW = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic             cnt_clear;
    logic [NS-1:0]    src_valid;
    logic [NS-1:0]    src_last;
    logic [NS*DW-1:0] src_data;
    logic [NS-1:0]    src_ready;
    logic [DW-1:0]    fifo_data;
    logic             fifo_wrreq;
    logic             fifo_wrfull;
    logic             busy;
    logic [2:0]       grant_id;
    logic [NS*CW-1:0] word_count;
    logic [CW-1:0]    stall_count;

    int n_cmp  = 0;
    int n_fail = 0;
    int seq [NS];

    typedef struct {
        logic       rst;
        logic       en;
        logic       clr;
        logic [2:0] v;
        logic [2:0] l;
        logic       full;
        logic       ewr;
        logic [2:0] erdy;
        logic       ebusy;
        logic [2:0] egid;
        int         eseq;
    } vec_t;

    vec_t vq [$];

    xcvr_tx_fifo_wr_arbiter #(
        .NUM_SRC(NS), .DATA_W(DW), .MAX_BURST(16), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .cnt_clear(cnt_clear),
        .src_valid(src_valid), .src_last(src_last), .src_data(src_data),
        .src_ready(src_ready), .fifo_data(fifo_data), .fifo_wrreq(fifo_wrreq),
        .fifo_wrfull(fifo_wrfull), .busy(busy), .grant_id(grant_id),
        .word_count(word_count), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mkword(input int s, input int q);
        return {32'(s), 64'hDEAD_BEEF_CAFE_F00D, 32'(q)};
    endfunction

    // Each source presents a numbered word stream; it advances only on a handshake.
    always_comb begin
        src_data = '0;
        for (int i = 0; i < NS; i++) src_data[i*DW +: DW] = mkword(i, seq[i]);
    end

    always @(posedge clk) begin
        for (int i = 0; i < NS; i++) begin
            if (reset) seq[i] <= 0;
            else if (src_valid[i] && src_ready[i]) seq[i] <= seq[i] + 1;
        end
    end

    function automatic logic [CW-1:0] wc(input int i);
        return word_count[i*CW +: CW];
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic en, input logic clr,
                       input logic [2:0] v, input logic [2:0] l, input logic full,
                       input logic ewr, input logic [2:0] erdy, input logic ebusy,
                       input logic [2:0] egid, input int eseq);
        vec_t t;
        t.rst = rst; t.en = en; t.clr = clr; t.v = v; t.l = l; t.full = full;
        t.ewr = ewr; t.erdy = erdy; t.ebusy = ebusy; t.egid = egid; t.eseq = eseq;
        vq.push_back(t);
    endtask

    task automatic run_vecs(input string tag);
        foreach (vq[i]) begin
            reset       = vq[i].rst;
            enable      = vq[i].en;
            cnt_clear   = vq[i].clr;
            src_valid   = vq[i].v;
            src_last    = vq[i].l;
            fifo_wrfull = vq[i].full;
            @(negedge clk);
            chk($sformatf("%s[%0d].wrreq", tag, i), DW'(fifo_wrreq), DW'(vq[i].ewr));
            chk($sformatf("%s[%0d].ready", tag, i), DW'(src_ready), DW'(vq[i].erdy));
            chk($sformatf("%s[%0d].busy", tag, i), DW'(busy), DW'(vq[i].ebusy));
            chk($sformatf("%s[%0d].grant_id", tag, i), DW'(grant_id), DW'(vq[i].egid));
            if (vq[i].ewr)
                chk($sformatf("%s[%0d].data", tag, i), fifo_data, mkword(int'(vq[i].egid), vq[i].eseq));
            else if (!vq[i].ebusy)
                chk($sformatf("%s[%0d].idle_data", tag, i), fifo_data, '0);
            @(posedge clk);
            #1;
        end
        vq.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; cnt_clear = 1'b0;
        src_valid = '0; src_last = '0; fifo_wrfull = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        // Reset state
        chk("rst.busy", DW'(busy), '0);
        chk("rst.grant_id", DW'(grant_id), '0);
        chk("rst.ready", DW'(src_ready), '0);
        chk("rst.wrreq", DW'(fifo_wrreq), '0);
        chk("rst.data", fifo_data, '0);
        chk("rst.word_count", DW'(word_count), '0);
        chk("rst.stall_count", DW'(stall_count), '0);

        // Single source, 4-beat burst
        add(0,1,0, 3'b001,3'b000,0, 0,3'b000,0,0,0);
        add(0,1,0, 3'b001,3'b000,0, 1,3'b001,1,0,0);
        add(0,1,0, 3'b001,3'b000,0, 1,3'b001,1,0,1);
        add(0,1,0, 3'b001,3'b000,0, 1,3'b001,1,0,2);
        add(0,1,0, 3'b001,3'b001,0, 1,3'b001,1,0,3);
        add(0,1,0, 3'b000,3'b000,0, 0,3'b000,0,0,0);
        run_vecs("single");
        chk("single.wc0", DW'(wc(0)), DW'(4));

        // Round robin, all valid, 2-beat bursts with a bubble between
        do_reset();
        add(0,1,0, 3'b111,3'b000,0, 0,3'b000,0,0,0);
        for (int r = 0; r < 6; r++) begin
            add(0,1,0, 3'b111,3'b000,0, 1,3'(1 << (r % 3)),1,3'(r % 3),2*(r/3));
            add(0,1,0, 3'b111,3'b111,0, 1,3'(1 << (r % 3)),1,3'(r % 3),2*(r/3)+1);
            add(0,1,0, 3'b111,3'b000,0, 0,3'b000,0,3'(r % 3),0);
        end
        run_vecs("rr");
        chk("rr.wc0", DW'(wc(0)), DW'(4));
        chk("rr.wc1", DW'(wc(1)), DW'(4));
        chk("rr.wc2", DW'(wc(2)), DW'(4));

        // Source 1 never marks last: forced release after 16 beats, then source 2
        do_reset();
        add(0,1,0, 3'b010,3'b000,0, 0,3'b000,0,0,0);
        for (int b = 0; b < 16; b++) add(0,1,0, 3'b110,3'b000,0, 1,3'b010,1,1,b);
        add(0,1,0, 3'b110,3'b000,0, 0,3'b000,0,1,0);
        add(0,1,0, 3'b110,3'b000,0, 1,3'b100,1,2,0);
        run_vecs("maxburst");
        chk("maxburst.wc1", DW'(wc(1)), DW'(16));
        chk("maxburst.wc2", DW'(wc(2)), DW'(1));

        // wrfull held for 5 cycles mid-burst
        do_reset();
        add(0,1,0, 3'b001,3'b000,0, 0,3'b000,0,0,0);
        add(0,1,0, 3'b001,3'b000,0, 1,3'b001,1,0,0);
        add(0,1,0, 3'b001,3'b000,0, 1,3'b001,1,0,1);
        for (int c = 0; c < 5; c++) add(0,1,0, 3'b001,3'b000,1, 0,3'b000,1,0,0);
        add(0,1,0, 3'b001,3'b000,0, 1,3'b001,1,0,2);
        add(0,1,0, 3'b001,3'b001,0, 1,3'b001,1,0,3);
        run_vecs("wrfull");
        chk("wrfull.stall_count", DW'(stall_count), DW'(5));
        chk("wrfull.wc0", DW'(wc(0)), DW'(4));

        // enable dropped mid-burst: burst completes, then idle until re-enabled
        do_reset();
        add(0,1,0, 3'b111,3'b000,0, 0,3'b000,0,0,0);
        add(0,1,0, 3'b111,3'b000,0, 1,3'b001,1,0,0);
        add(0,0,0, 3'b111,3'b000,0, 1,3'b001,1,0,1);
        add(0,0,0, 3'b111,3'b000,0, 1,3'b001,1,0,2);
        add(0,0,0, 3'b111,3'b111,0, 1,3'b001,1,0,3);
        add(0,0,0, 3'b111,3'b000,0, 0,3'b000,0,0,0);
        add(0,0,0, 3'b111,3'b000,0, 0,3'b000,0,0,0);
        add(0,1,0, 3'b111,3'b000,0, 0,3'b000,0,0,0);
        add(0,1,0, 3'b111,3'b000,0, 1,3'b010,1,1,0);
        run_vecs("enable");
        chk("enable.wc0", DW'(wc(0)), DW'(4));
        chk("enable.wc1", DW'(wc(1)), DW'(1));

        // Reset mid-burst at beat 3, then clear coinciding with an accepted beat
        do_reset();
        add(0,1,0, 3'b001,3'b000,0, 0,3'b000,0,0,0);
        add(0,1,0, 3'b001,3'b000,0, 1,3'b001,1,0,0);
        add(0,1,0, 3'b001,3'b000,0, 1,3'b001,1,0,1);
        add(1,1,0, 3'b001,3'b000,0, 0,3'b000,1,0,0);
        run_vecs("midrst");
        chk("midrst.wc0", DW'(wc(0)), '0);
        chk("midrst.stall", DW'(stall_count), '0);
        add(0,1,0, 3'b011,3'b000,0, 0,3'b000,0,0,0);
        add(0,1,1, 3'b011,3'b000,0, 1,3'b001,1,0,0);
        run_vecs("clear");
        chk("clear.wc0", DW'(wc(0)), '0);
        add(0,1,0, 3'b001,3'b001,0, 1,3'b001,1,0,1);
        run_vecs("postclr");
        chk("postclr.wc0", DW'(wc(0)), DW'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
